// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM states, grant owner and
// the width of the access-latency counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic {
        GNT_IF,
        GNT_D
    } grant_e;

    localparam int LATENCY_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants won while a fetch was waiting; raises
// forceFetch once the fetch has been passed over MAX_STARVE times in a row.
module mem_arb_starve_ctr #(
    parameter int MAX_STARVE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic grantD,
    input  logic grantIf,
    input  logic ifReq,
    output logic forceFetch
);

    localparam int CW = $clog2(MAX_STARVE + 1);

    logic [CW-1:0] starveCnt;

    // A fetch grant, or a data grant with no fetch waiting, ends the streak.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starveCnt <= '0;
        end else if (grantIf || (grantD && !ifReq)) begin
            starveCnt <= '0;
        end else if (grantD && starveCnt != CW'(MAX_STARVE)) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end

    assign forceFetch = (starveCnt == CW'(MAX_STARVE));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch and data ports.
// Define MEM_ARB_STARVE_GUARD_EN to let a starved fetch override data priority.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2,
    parameter int MAX_STARVE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    if (LATENCY < 1 || LATENCY > 15 || MAX_STARVE < 1) begin : gBadConfig
        $error("unified_mem_arbiter: LATENCY must be 1..15 and MAX_STARVE >= 1");
    end

    state_e                state;
    grant_e                grant;
    logic [LATENCY_W-1:0]  cnt;
    logic                  latWe;
    logic [DATA_WIDTH-1:0] latAddr;
    logic [DATA_WIDTH-1:0] latWdata;
    logic                  forceFetch;
    logic                  grantD;
    logic                  grantIf;

    // Data is the older instruction, so it wins unless a starved fetch is forced.
    assign grantD  = (state == IDLE) && d_req && !(if_req && forceFetch);
    assign grantIf = (state == IDLE) && if_req && !grantD;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .MAX_STARVE(MAX_STARVE)
    ) uStarveCtr (
        .clk       (clk),
        .reset     (reset),
        .grantD    (grantD),
        .grantIf   (grantIf),
        .ifReq     (if_req),
        .forceFetch(forceFetch)
    );
`else
    assign forceFetch = 1'b0;
`endif

    assign mem_addr  = latAddr;
    assign mem_wdata = latWdata;

    // DONE always sits between accesses so a request still high during its
    // ready cycle is dropped by the core before IDLE samples it again.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= GNT_IF;
            cnt      <= '0;
            latWe    <= 1'b0;
            latAddr  <= '0;
            latWdata <= '0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantD) begin
                        grant    <= GNT_D;
                        latWe    <= d_we;
                        latAddr  <= d_addr;
                        latWdata <= d_wdata;
                        mem_we   <= d_we;
                    end else if (grantIf) begin
                        grant    <= GNT_IF;
                        latWe    <= 1'b0;
                        latAddr  <= if_addr;
                        latWdata <= '0;
                        mem_we   <= 1'b0;
                    end
                    if (grantD || grantIf) begin
                        cnt    <= LATENCY_W'(LATENCY - 1);
                        mem_en <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (grant == GNT_D) begin
                            d_ready <= 1'b1;
                            if (!latWe) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter (LATENCY=2, MAX_STARVE=3);
// expectations follow MEM_ARB_STARVE_GUARD_EN when it is defined.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] memArray [0:255];
    int          checks = 0;
    int          errors = 0;
    int          accessCount = 0;
    logic        prevEn = 1'b0;
    logic        bothReadySeen = 1'b0;

    unified_mem_arbiter #(
        .DATA_WIDTH(32),
        .LATENCY   (2),
        .MAX_STARVE(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory model; preload held while reset is low.
    assign mem_rdata = memArray[mem_addr[9:2]];

    always @(posedge clk) begin
        if (!reset) begin
            memArray[16] <= 32'hDEADBEEF;
            memArray[64] <= 32'hE3A00001;
        end else if (mem_en && mem_we) begin
            memArray[mem_addr[9:2]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_en && !prevEn) accessCount++;
        prevEn = mem_en;
        if (if_ready && d_ready) bothReadySeen = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr, input logic dReq,
                                 input logic dWe, input logic [31:0] dAddr, input logic [31:0] dWdata);
        if_req  = ifReq;
        if_addr = ifAddr;
        d_req   = dReq;
        d_we    = dWe;
        d_addr  = dAddr;
        d_wdata = dWdata;
    endtask

    task automatic dataAccess(input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] expRdata);
        int lat;
        applyStimulus(1'b0, 32'h0, 1'b1, we, addr, wdata);
        lat = 0;
        while (!d_ready && lat < 20) begin
            step();
            lat++;
        end
        checkOutput({tag, "Latency"}, 32'(lat), 32'd3);
        checkOutput({tag, "Rdata"}, d_rdata, expRdata);
        d_req = 1'b0;
        step();
    endtask

    initial begin
        int base;
        int dCount;
        int ifPos;
        logic ifDone;

        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        checkOutput("resetMemEn", {31'b0, mem_en}, 32'd0);
        checkOutput("resetMemWe", {31'b0, mem_we}, 32'd0);
        checkOutput("resetReady", {30'b0, if_ready, d_ready}, 32'd0);
        checkOutput("resetDRdata", d_rdata, 32'h0);
        checkOutput("resetIfRdata", if_rdata, 32'h0);
        checkOutput("resetMemAddr", mem_addr, 32'h0);
        reset = 1'b1;
        step();

        // Load with cycle-by-cycle timing
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        step();
        checkOutput("loadC1MemEn", {31'b0, mem_en}, 32'd1);
        checkOutput("loadC1MemWe", {31'b0, mem_we}, 32'd0);
        checkOutput("loadC1MemAddr", mem_addr, 32'h40);
        step();
        checkOutput("loadC2MemEn", {31'b0, mem_en}, 32'd1);
        checkOutput("loadC2Ready", {31'b0, d_ready}, 32'd0);
        step();
        checkOutput("loadC3Ready", {30'b0, if_ready, d_ready}, 32'd1);
        checkOutput("loadC3MemEn", {31'b0, mem_en}, 32'd0);
        checkOutput("loadC3Rdata", d_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        step();
        checkOutput("loadC4Ready", {31'b0, d_ready}, 32'd0);

        // Store then load back
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h12345678);
        step();
        checkOutput("storeC1MemWe", {31'b0, mem_we}, 32'd1);
        checkOutput("storeC1Wdata", mem_wdata, 32'h12345678);
        step();
        checkOutput("storeC2MemWe", {31'b0, mem_we}, 32'd1);
        step();
        checkOutput("storeC3Ready", {31'b0, d_ready}, 32'd1);
        checkOutput("storeC3MemWe", {31'b0, mem_we}, 32'd0);
        checkOutput("storeKeepsRdata", d_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        step();
        dataAccess("loadAfterStore", 1'b0, 32'h80, 32'h0, 32'h12345678);

        // Contention: data first, fetch next
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h40, 32'h0);
        step();
        checkOutput("contC1MemAddr", mem_addr, 32'h40);
        step();
        step();
        checkOutput("contC3Ready", {30'b0, if_ready, d_ready}, 32'd1);
        d_req = 1'b0;
        step();
        step();
        checkOutput("contC5MemAddr", mem_addr, 32'h100);
        step();
        step();
        checkOutput("contC7Ready", {30'b0, if_ready, d_ready}, 32'd2);
        checkOutput("contC7IfRdata", if_rdata, 32'hE3A00001);
        if_req = 1'b0;
        step();

        // Fetch request held through its ready cycle is served once
        base = accessCount;
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        step();
        checkOutput("heldReady", {30'b0, if_ready, d_ready}, 32'd2);
        if_req = 1'b0;
        for (int i = 0; i < 6; i++) step();
        checkOutput("heldAccessCount", 32'(accessCount - base), 32'd1);

        // Starvation: fetch waiting behind back-to-back loads
        dCount = 0;
        ifPos  = -1;
        ifDone = 1'b0;
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h40, 32'h0);
        for (int c = 0; c < 80 && !(dCount == 4 && ifDone); c++) begin
            step();
            if (d_ready) begin
                dCount++;
                if (dCount == 4) d_req = 1'b0;
            end
            if (if_ready) begin
                ifPos  = dCount;
                ifDone = 1'b1;
                if_req = 1'b0;
            end
        end
        checkOutput("starveDataCount", 32'(dCount), 32'd4);
        checkOutput("starveFetchDone", {31'b0, ifDone}, 32'd1);
`ifdef MEM_ARB_STARVE_GUARD_EN
        checkOutput("starveFetchSlot", 32'(ifPos), 32'd3);
`else
        checkOutput("starveFetchSlot", 32'(ifPos), 32'd4);
`endif
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();

        // Reset asserted mid-access
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
        step();
        checkOutput("midBusyMemEn", {31'b0, mem_en}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("midResetMemEn", {31'b0, mem_en}, 32'd0);
        checkOutput("midResetReady", {30'b0, if_ready, d_ready}, 32'd0);
        checkOutput("midResetDRdata", d_rdata, 32'h0);
        checkOutput("midResetIfRdata", if_rdata, 32'h0);
        d_req = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        dataAccess("loadAfterReset", 1'b0, 32'h80, 32'h0, 32'h12345678);

        checkOutput("neverBothReady", {31'b0, bothReadySeen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port and data (M-stage) port.
- Sequences each access through a fixed-latency memory: grant, hold the address/control for LATENCY cycles, capture read data, then pulse a per-port ready.
- Sits between the arm core and the unified memory, replacing the separate instruction and data memories. The core's hazard unit stalls F/M while ready is low.

Parameters:
- DATA_WIDTH, 32, word width of data, addresses and memory bus.
- LATENCY, 2, memory cycles per access (legal range 1..15).
- MAX_STARVE, 3, consecutive data grants after which a waiting fetch is forced (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  DATA_WIDTH  fetch byte address (PCF).
- if_rdata  out  DATA_WIDTH  fetched instruction; registered.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  DATA_WIDTH  data byte address (ALUOutM).
- d_wdata  in  DATA_WIDTH  store data (WriteDataM).
- d_rdata  out  DATA_WIDTH  load data (ReadDataM); registered.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  DATA_WIDTH  memory byte address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid LATENCY cycles after mem_en rises.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all outputs 0, including if_rdata/d_rdata; count = 0; starvation count = 0.
  - An access in flight is abandoned: no ready pulse, no write completion guaranteed.
- States and transitions:
  - IDLE: if any request is present, latch the winner's address/we/wdata into registers and go to BUSY with cnt = LATENCY-1. Otherwise stay in IDLE.
  - BUSY: mem_en = 1, mem_we = latched we, mem outputs driven from latched registers. While cnt != 0, decrement. At cnt == 0: on a load, capture mem_rdata into the winner's rdata register, then go to DONE.
  - DONE: assert the winner's ready for exactly one cycle, then go to IDLE. mem_en = 0.
- Latency: request first seen in cycle 0 gives ready in cycle LATENCY+1. The minimum issue interval is LATENCY+2 cycles per access.
- The DONE state guarantees that a req still high during the ready cycle is not re-served.
- Arbitration in IDLE:
  - Data wins when both requests are present, because the M-stage instruction is older.
  - Fetch is served only when d_req = 0.
- Stores leave d_rdata unchanged. Each rdata register holds its value until the next load on that port.
- Requester inputs are ignored outside IDLE; changing them mid-access has no effect.
- No alignment checking: addresses pass through unchanged; the memory ignores bits [1:0].
- The unselected port's ready stays 0. if_ready and d_ready are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- With the macro:
  - A saturating counter increments on each data grant made while if_req = 1.
  - It clears on each fetch grant, and when if_req = 0 at a data grant.
  - When the counter reaches MAX_STARVE and both requests are present, fetch wins.
- Without the macro: strict data priority; no counter logic is synthesized.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - grant encoding {GNT_IF, GNT_D};
  - LATENCY_W = 4 (counter width).
- Sub-module mem_arb_starve_ctr: saturating counter with a force-fetch output. Instantiated only under the macro.

Test Plan:
- Load: d_req=1, d_we=0, d_addr=0x40, memory[0x40]=0xDEADBEEF, LATENCY=2 -> mem_en high for cycles 1-2, d_ready pulse in cycle 3, d_rdata=0xDEADBEEF.
- Store then load: store 0x12345678 to 0x80, then load 0x80 -> mem_we=1 only during the store's BUSY cycles; load returns 0x12345678; d_rdata unchanged after the store.
- Contention: if_req and d_req both high in cycle 0 -> data served first (d_ready in cycle 3), fetch served next (if_ready in cycle 7). Never both ready in one cycle.
- Starvation guard: macro defined, MAX_STARVE=3, if_req held high and 4 back-to-back loads -> the 4th grant goes to fetch. Macro undefined -> all 4 loads are served before the fetch.
- Held request: if_req stays high through the if_ready cycle and then drops -> exactly one memory access is issued.
- Reset mid-access: reset=0 during BUSY -> mem_en=0 and ready=0 immediately; after release, state is IDLE and a new load completes normally.
